wb_mem_responder: RTL and testbench

WB_MEM_RESPONDER -- requirements
Module: wb_mem_responder

---
 rtl/wb_mem_responder.sv | 146 ++++++++++++++
 tb/tb_wb_mem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_responder.sv
// Wishbone byte-wide memory responder with a side loader port and programmable wait states.
// With READ_ONLY set it behaves as a boot ROM: Wishbone writes are answered with an error.
module wb_mem_responder #(
    parameter int unsigned ADDR_BITS   = 14,
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int unsigned WAIT_STATES = 1,
    parameter bit          READ_ONLY   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic [23:0]          wb_adr_i,
    input  logic                 wb_we_i,
    input  logic [7:0]           wb_dat_i,
    output logic [7:0]           wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    input  logic                 ld_we,
    input  logic [ADDR_BITS-1:0] ld_adr,
    input  logic [7:0]           ld_dat,
    output logic                 busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] adr_q, adr_d;
    logic                 we_q, we_d;
    logic [7:0]           wdat_q, wdat_d;
    logic [7:0]           dat_q, dat_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    logic [7:0]           mem_q [DEPTH];
    logic [ADDR_BITS-1:0] rd_off;
    logic                 req;
    logic                 hit;

    assign req = wb_cyc_i & wb_stb_i;
    // Full upper-bit compare: neighbouring windows never alias onto this one.
    assign hit = (wb_adr_i[23:ADDR_BITS] == BASE_ADDR[23:ADDR_BITS]) && !(READ_ONLY && wb_we_i);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        we_d    = we_q;
        wdat_d  = wdat_q;
        dat_d   = dat_q;
        rd_off  = adr_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    adr_d  = wb_adr_i[ADDR_BITS-1:0];
                    we_d   = wb_we_i;
                    wdat_d = wb_dat_i;
                    cnt_d  = CNT_W'(WAIT_STATES);
                    rd_off = wb_adr_i[ADDR_BITS-1:0];
                    if (!hit) begin
                        state_d = ERR;
                    end else if (WAIT_STATES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Only cyc aborts; a dropped stb alone keeps the transfer alive.
                if (!wb_cyc_i) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Read data lands on the edge entering RESP and is held afterwards.
        if (state_d == RESP && !we_d) begin
            dat_d = mem_q[rd_off];
        end

        ack_d  = (state_d == RESP);
        err_d  = (state_d == ERR);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            we_q    <= 1'b0;
            wdat_q  <= '0;
            dat_q   <= 8'h00;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Storage is not reset; the loader write comes last so it wins a same-offset collision.
    always_ff @(posedge clk) begin
        if (state_q == RESP && we_q) begin
            mem_q[adr_q] <= wdat_q;
        end
        if (ld_we) begin
            mem_q[ld_adr] <= ld_dat;
        end
    end

    assign wb_dat_o = dat_q;
    assign wb_ack_o = ack_q;
    assign wb_err_o = err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench: three responder instances cover boot-ROM, slow read/write and zero-wait streaming configurations.
module tb_wb_mem_responder;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    logic        a_cyc, a_stb, a_we, a_ldwe, a_ack, a_err, a_busy;
    logic [23:0] a_adr;
    logic [7:0]  a_dati, a_dato, a_lddat;
    logic [13:0] a_ldadr;

    logic        b_cyc, b_stb, b_we, b_ldwe, b_ack, b_err, b_busy;
    logic [23:0] b_adr;
    logic [7:0]  b_dati, b_dato, b_lddat;
    logic [13:0] b_ldadr;

    logic        c_cyc, c_stb, c_we, c_ldwe, c_ack, c_err, c_busy;
    logic [23:0] c_adr;
    logic [7:0]  c_dati, c_dato, c_lddat;
    logic [13:0] c_ldadr;

    wb_mem_responder #(.ADDR_BITS(14), .BASE_ADDR(24'h000000), .WAIT_STATES(1), .READ_ONLY(1'b1)) u_a (
        .clk(clk), .rst(rst),
        .wb_cyc_i(a_cyc), .wb_stb_i(a_stb), .wb_adr_i(a_adr), .wb_we_i(a_we), .wb_dat_i(a_dati),
        .wb_dat_o(a_dato), .wb_ack_o(a_ack), .wb_err_o(a_err),
        .ld_we(a_ldwe), .ld_adr(a_ldadr), .ld_dat(a_lddat), .busy(a_busy)
    );

    wb_mem_responder #(.ADDR_BITS(14), .BASE_ADDR(24'h000000), .WAIT_STATES(3), .READ_ONLY(1'b0)) u_b (
        .clk(clk), .rst(rst),
        .wb_cyc_i(b_cyc), .wb_stb_i(b_stb), .wb_adr_i(b_adr), .wb_we_i(b_we), .wb_dat_i(b_dati),
        .wb_dat_o(b_dato), .wb_ack_o(b_ack), .wb_err_o(b_err),
        .ld_we(b_ldwe), .ld_adr(b_ldadr), .ld_dat(b_lddat), .busy(b_busy)
    );

    wb_mem_responder #(.ADDR_BITS(14), .BASE_ADDR(24'h000000), .WAIT_STATES(0), .READ_ONLY(1'b0)) u_c (
        .clk(clk), .rst(rst),
        .wb_cyc_i(c_cyc), .wb_stb_i(c_stb), .wb_adr_i(c_adr), .wb_we_i(c_we), .wb_dat_i(c_dati),
        .wb_dat_o(c_dato), .wb_ack_o(c_ack), .wb_err_o(c_err),
        .ld_we(c_ldwe), .ld_adr(c_ldadr), .ld_dat(c_lddat), .busy(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One slow-instance transfer: acceptance edge plus three wait edges, ack on the fourth.
    task automatic b_xfer(input string tag, input logic [23:0] adr, input logic we,
                          input logic [7:0] wdat, input logic [7:0] exp_rd);
        b_cyc = 1'b1; b_stb = 1'b1; b_adr = adr; b_we = we; b_dati = wdat;
        tick(); tick(); tick();
        chk({tag, "_noack_early"}, 32'(b_ack), 32'd0);
        tick();
        chk({tag, "_ack"}, 32'(b_ack), 32'd1);
        if (!we) chk({tag, "_rdata"}, 32'(b_dato), 32'(exp_rd));
        b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
        tick();
    endtask

    initial begin
        tests = 0; fails = 0;
        rst = 1'b1;
        a_cyc = 0; a_stb = 0; a_we = 0; a_adr = '0; a_dati = '0; a_ldwe = 0; a_ldadr = '0; a_lddat = '0;
        b_cyc = 0; b_stb = 0; b_we = 0; b_adr = '0; b_dati = '0; b_ldwe = 0; b_ldadr = '0; b_lddat = '0;
        c_cyc = 0; c_stb = 0; c_we = 0; c_adr = '0; c_dati = '0; c_ldwe = 0; c_ldadr = '0; c_lddat = '0;

        // Loader works while reset is held.
        tick();
        a_ldwe = 1'b1; a_ldadr = 14'h0010; a_lddat = 8'hA5;
        tick();
        a_ldadr = 14'h0020; a_lddat = 8'h5A;
        tick();
        a_ldwe = 1'b0;
        tick();
        chk("rst_ack", 32'(a_ack), 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_dato", 32'(a_dato), 32'h00);
        chk("rst_busy", 32'(a_busy), 32'd0);

        // First request accepted on the first edge after reset release.
        rst = 1'b0;
        a_cyc = 1'b1; a_stb = 1'b1; a_adr = 24'h000010; a_we = 1'b0;
        tick();
        chk("rd1_busy", 32'(a_busy), 32'd1);
        chk("rd1_noack_n1", 32'(a_ack), 32'd0);
        // Loader overwrites the same byte on the edge the read lands: old data returned.
        a_ldwe = 1'b1; a_ldadr = 14'h0010; a_lddat = 8'hC3;
        tick();
        a_ldwe = 1'b0;
        chk("rd1_ack", 32'(a_ack), 32'd1);
        chk("rd1_err", 32'(a_err), 32'd0);
        chk("rd1_data", 32'(a_dato), 32'hA5);
        a_cyc = 1'b0; a_stb = 1'b0;
        tick();
        chk("rd1_ack_once", 32'(a_ack), 32'd0);
        chk("rd1_idle", 32'(a_busy), 32'd0);
        chk("rd1_hold", 32'(a_dato), 32'hA5);

        // Write to the boot ROM errors and leaves the byte untouched.
        a_cyc = 1'b1; a_stb = 1'b1; a_adr = 24'h000020; a_we = 1'b1; a_dati = 8'h3C;
        tick();
        chk("ro_wr_err", 32'(a_err), 32'd1);
        chk("ro_wr_noack", 32'(a_ack), 32'd0);
        a_cyc = 1'b0; a_stb = 1'b0; a_we = 1'b0;
        tick();
        chk("ro_wr_err_once", 32'(a_err), 32'd0);
        a_cyc = 1'b1; a_stb = 1'b1; a_adr = 24'h000020;
        tick();
        tick();
        chk("ro_rd_ack", 32'(a_ack), 32'd1);
        chk("ro_rd_data", 32'(a_dato), 32'h5A);
        a_cyc = 1'b0; a_stb = 1'b0;
        tick();

        // Adjacent window errors one cycle after acceptance.
        a_cyc = 1'b1; a_stb = 1'b1; a_adr = 24'h004000;
        tick();
        chk("oow_err", 32'(a_err), 32'd1);
        chk("oow_noack", 32'(a_ack), 32'd0);
        chk("oow_hold", 32'(a_dato), 32'h5A);
        a_cyc = 1'b0; a_stb = 1'b0;
        tick();
        chk("oow_err_once", 32'(a_err), 32'd0);

        // stb dropped in WAIT with cyc held still completes; sees loader's C3.
        a_cyc = 1'b1; a_stb = 1'b1; a_adr = 24'h000010;
        tick();
        a_stb = 1'b0;
        tick();
        chk("stb_drop_ack", 32'(a_ack), 32'd1);
        chk("stb_drop_data", 32'(a_dato), 32'hC3);
        a_cyc = 1'b0;
        tick();

        // Zero-wait streaming: 4 writes then 4 reads, cyc/stb held high throughout.
        c_cyc = 1'b1; c_stb = 1'b1; c_we = 1'b1; c_adr = 24'h000100; c_dati = 8'h10;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("stream%0d_ack", i), 32'(c_ack), 32'd1);
            if (i >= 4) chk($sformatf("stream%0d_data", i), 32'(c_dato), 32'(8'h10 + 8'(8'h11 * (i - 4))));
            c_we   = (i + 1 < 4);
            c_adr  = 24'h000100 + 24'((i + 1) % 4);
            c_dati = 8'h10 + 8'(8'h11 * ((i + 1) % 4));
            tick();
            chk($sformatf("stream%0d_gap", i), 32'(c_ack), 32'd0);
        end
        c_cyc = 1'b0; c_stb = 1'b0; c_we = 1'b0;
        tick();

        // Slow instance: write, read back, then an aborted overwrite.
        b_xfer("b_wr5", 24'h000005, 1'b1, 8'h77, 8'h00);
        b_xfer("b_rd5", 24'h000005, 1'b0, 8'h00, 8'h77);
        b_cyc = 1'b1; b_stb = 1'b1; b_adr = 24'h000005; b_we = 1'b1; b_dati = 8'h99;
        tick();
        tick();
        b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
        tick();
        chk("abort_busy", 32'(b_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("abort_quiet%0d", i), 32'({b_ack, b_err}), 32'd0);
        end
        b_xfer("b_rd5_after_abort", 24'h000005, 1'b0, 8'h00, 8'h77);

        // Loader and Wishbone write collide on offset 6 at the commit edge: loader wins.
        b_cyc = 1'b1; b_stb = 1'b1; b_adr = 24'h000006; b_we = 1'b1; b_dati = 8'h11;
        tick(); tick(); tick(); tick();
        chk("coll_ack", 32'(b_ack), 32'd1);
        b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
        b_ldwe = 1'b1; b_ldadr = 14'h0006; b_lddat = 8'h22;
        tick();
        b_ldwe = 1'b0;
        b_xfer("b_rd6", 24'h000006, 1'b0, 8'h00, 8'h22);

        // Reset during WAIT of a write clears outputs at once and suppresses the write.
        b_cyc = 1'b1; b_stb = 1'b1; b_adr = 24'h000005; b_we = 1'b1; b_dati = 8'hEE;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(b_busy), 32'd0);
        chk("rst_mid_dato", 32'(b_dato), 32'h00);
        chk("rst_mid_resp", 32'({b_ack, b_err}), 32'd0);
        b_cyc = 1'b0; b_stb = 1'b0; b_we = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        b_xfer("b_rd5_after_rst", 24'h000005, 1'b0, 8'h00, 8'h77);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
